// File: rtl/fp_topk_select_if.sv
// Candidate stream in, sorted top-K result set out.
// DUT uses slave; the producer/consumer side uses master.
interface fp_topk_select_if #(
    parameter int DW = 32,
    parameter int K  = 4,
    parameter int IW = 16
);
    logic            in_vld;
    logic            in_rdy;
    logic [IW-1:0]   in_idx;
    logic [DW-1:0]   in_dat;
    logic            in_last;
    logic            out_vld;
    logic            out_rdy;
    logic [K*IW-1:0] out_idx;
    logic [K*DW-1:0] out_dat;
    logic [K-1:0]    out_msk;

    modport master (
        output in_vld, in_idx, in_dat, in_last, out_rdy,
        input  in_rdy, out_vld, out_idx, out_dat, out_msk
    );

    modport slave (
        input  in_vld, in_idx, in_dat, in_last, out_rdy,
        output in_rdy, out_vld, out_idx, out_dat, out_msk
    );
endinterface

// File: rtl/fp_topk_select.sv
// Streaming K-smallest selector over sign-magnitude distances.
// One-cycle sorted insertion; result held until the consumer accepts.
module fp_topk_select #(
    parameter int DW = 32,
    parameter int K  = 4,
    parameter int IW = 16
) (
    input logic           clk,
    input logic           rst,
    fp_topk_select_if.slave s
);
    typedef enum logic {COLLECT, DONE} state_t;

    state_t        r_state;
    logic          r_in_rdy;
    logic          r_out_vld;
    logic [IW-1:0] r_idx [K];
    logic [DW-1:0] r_dat [K];
    logic [K-1:0]  r_msk;

    logic          w_xfer;
    logic          w_done;
    logic [DW-1:0] w_nkey;
    logic [K-1:0]  w_lt;
    logic [IW-1:0] w_nidx [K];
    logic [DW-1:0] w_ndat [K];
    logic [K-1:0]  w_nmsk;
    logic [K*IW-1:0] w_oidx;
    logic [K*DW-1:0] w_odat;

    // Unsigned key whose order matches sign-magnitude order; +0 == -0.
    function automatic logic [DW-1:0] f_key(input logic [DW-1:0] d);
        if (d[DW-2:0] == '0)
            return {1'b1, {(DW-1){1'b0}}};
        else if (d[DW-1])
            return ~d;
        else
            return {1'b1, d[DW-2:0]};
    endfunction

    assign w_xfer = s.in_vld && r_in_rdy;
    assign w_done = r_out_vld && s.out_rdy;

    // Slot-wise "new candidate goes at or before here"; empties always lose.
    always_comb begin
        w_nkey = f_key(s.in_dat);
        w_lt   = '0;
        for (int i = 0; i < K; i++)
            w_lt[i] = !r_msk[i] || (w_nkey < f_key(r_dat[i]));
    end

    // Shifted slot contents: first true slot takes the candidate, later ones shift up.
    always_comb begin
        w_nidx[0] = w_lt[0] ? s.in_idx : r_idx[0];
        w_ndat[0] = w_lt[0] ? s.in_dat : r_dat[0];
        w_nmsk[0] = w_lt[0] ? 1'b1     : r_msk[0];
        for (int i = 1; i < K; i++) begin
            if (!w_lt[i]) begin
                w_nidx[i] = r_idx[i];
                w_ndat[i] = r_dat[i];
                w_nmsk[i] = r_msk[i];
            end else if (w_lt[i-1]) begin
                w_nidx[i] = r_idx[i-1];
                w_ndat[i] = r_dat[i-1];
                w_nmsk[i] = r_msk[i-1];
            end else begin
                w_nidx[i] = s.in_idx;
                w_ndat[i] = s.in_dat;
                w_nmsk[i] = 1'b1;
            end
        end
    end

    // Pack slot registers onto the result bus, slot 0 in the low bits.
    always_comb begin
        w_oidx = '0;
        w_odat = '0;
        for (int i = 0; i < K; i++) begin
            w_oidx[i*IW +: IW] = r_idx[i];
            w_odat[i*DW +: DW] = r_dat[i];
        end
    end

    assign s.in_rdy  = r_in_rdy;
    assign s.out_vld = r_out_vld;
    assign s.out_idx = w_oidx;
    assign s.out_dat = w_odat;
    assign s.out_msk = r_msk;

    // Collect/hand-off FSM with registered handshakes and slot storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= COLLECT;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
            r_msk     <= '0;
            for (int i = 0; i < K; i++) begin
                r_idx[i] <= '0;
                r_dat[i] <= '1;
            end
        end else begin
            unique case (r_state)
                COLLECT: begin
                    r_in_rdy <= 1'b1;
                    if (w_xfer) begin
                        r_msk <= w_nmsk;
                        for (int i = 0; i < K; i++) begin
                            r_idx[i] <= w_nidx[i];
                            r_dat[i] <= w_ndat[i];
                        end
                        if (s.in_last) begin
                            r_state   <= DONE;
                            r_in_rdy  <= 1'b0;
                            r_out_vld <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_done) begin
                        r_state   <= COLLECT;
                        r_in_rdy  <= 1'b1;
                        r_out_vld <= 1'b0;
                        r_msk     <= '0;
                        for (int i = 0; i < K; i++) begin
                            r_idx[i] <= '0;
                            r_dat[i] <= '1;
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_topk_select.sv
// Bench for fp_topk_select: directed queries, scoreboard-checked results.
// Monitor pops one expected result set each time out_vld rises.
module tb_fp_topk_select;
    localparam int DW = 32;
    localparam int K  = 4;
    localparam int IW = 16;

    typedef struct {
        logic [K*IW-1:0] idx;
        logic [K*DW-1:0] dat;
        logic [K-1:0]    msk;
        int              cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;
    bit   seen;
    exp_t q[$];

    logic [K*IW-1:0] e_idx;
    logic [K*DW-1:0] e_dat;
    logic [K-1:0]    e_msk;

    fp_topk_select_if #(.DW(DW), .K(K), .IW(IW)) bus ();

    fp_topk_select #(.DW(DW), .K(K), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [IW-1:0] idx, input logic [DW-1:0] dat,
                        input bit last);
        int n;
        exp_t e;
        bus.in_vld  = 1'b1;
        bus.in_idx  = idx;
        bus.in_dat  = dat;
        bus.in_last = last;
        n = 0;
        while (!bus.in_rdy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_rdy) chk("in_rdy_timeout", 128'(bus.in_rdy), 128'd1);
        @(posedge clk);
        #1;
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
        if (last) begin
            e.idx = e_idx;
            e.dat = e_dat;
            e.msk = e_msk;
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    // Scoreboard monitor: compare once per result presentation.
    always @(negedge clk) begin
        exp_t e;
        if (!bus.out_vld) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got idx %h with nothing expected",
                         bus.out_idx);
            end else begin
                e = q.pop_front();
                chk("res_idx", 128'(bus.out_idx), 128'(e.idx));
                chk("res_dat", 128'(bus.out_dat), 128'(e.dat));
                chk("res_msk", 128'(bus.out_msk), 128'(e.msk));
                chk("res_latency_cyc", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        seen    = 1'b0;
        rst     = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_idx  = '0;
        bus.in_dat  = '0;
        bus.in_last = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", 128'(bus.out_vld), 128'd0);
        chk("rst_out_msk", 128'(bus.out_msk), 128'd0);
        chk("rst_out_idx", 128'(bus.out_idx), 128'd0);
        chk("rst_out_dat", 128'(bus.out_dat), {128{1'b1}});
        chk("rst_in_rdy",  128'(bus.in_rdy),  128'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_rdy_low", 128'(bus.in_rdy), 128'd0);
        @(posedge clk);
        #1;
        chk("rel_in_rdy_high", 128'(bus.in_rdy), 128'd1);

        // Six candidates back to back, keep the four smallest.
        e_idx = {16'd4, 16'd1, 16'd5, 16'd3};
        e_dat = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        e_msk = 4'b1111;
        send(16'd0, 32'h40A00000, 1'b0);
        send(16'd1, 32'h40400000, 1'b0);
        send(16'd2, 32'h41000000, 1'b0);
        send(16'd3, 32'h3F800000, 1'b0);
        send(16'd4, 32'h40800000, 1'b0);
        send(16'd5, 32'h40000000, 1'b1);
        @(posedge clk);
        #1;
        chk("q1_cleared_vld", 128'(bus.out_vld), 128'd0);
        chk("q1_cleared_msk", 128'(bus.out_msk), 128'd0);
        chk("q1_in_rdy_back", 128'(bus.in_rdy),  128'd1);

        // Short query: two real slots, two empties.
        e_idx = {16'd0, 16'd0, 16'd7, 16'd9};
        e_dat = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'h3F800000};
        e_msk = 4'b0011;
        send(16'd7, 32'h40000000, 1'b0);
        send(16'd9, 32'h3F800000, 1'b1);

        // Ties stay in arrival order; -0 equals +0.
        e_idx = {16'd2, 16'd1, 16'd4, 16'd3};
        e_dat = {32'h40000000, 32'h40000000, 32'h00000000, 32'h80000000};
        e_msk = 4'b1111;
        send(16'd1, 32'h40000000, 1'b0);
        send(16'd2, 32'h40000000, 1'b0);
        send(16'd3, 32'h80000000, 1'b0);
        send(16'd4, 32'h00000000, 1'b1);

        // Negatives order below positives, larger magnitude first.
        e_idx = {16'd0, 16'd12, 16'd10, 16'd11};
        e_dat = {32'hFFFFFFFF, 32'h3F000000, 32'hBF800000, 32'hC0400000};
        e_msk = 4'b0111;
        send(16'd10, 32'hBF800000, 1'b0);
        send(16'd11, 32'hC0400000, 1'b0);
        send(16'd12, 32'h3F000000, 1'b1);

        // Full set drops equal/larger entries; then back-pressure hold.
        e_idx = {16'd23, 16'd22, 16'd21, 16'd20};
        e_dat = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        e_msk = 4'b1111;
        send(16'd20, 32'h3F800000, 1'b0);
        send(16'd21, 32'h40000000, 1'b0);
        send(16'd22, 32'h40400000, 1'b0);
        send(16'd23, 32'h40800000, 1'b0);
        send(16'd24, 32'h40800000, 1'b0);
        bus.out_rdy = 1'b0;
        send(16'd25, 32'h40A00000, 1'b1);
        bus.in_vld = 1'b1;
        bus.in_idx = 16'd99;
        bus.in_dat = 32'hC0400000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_rdy",  128'(bus.in_rdy),  128'd0);
            chk("hold_out_vld", 128'(bus.out_vld), 128'd1);
            chk("hold_out_idx", 128'(bus.out_idx), 128'(e_idx));
            chk("hold_out_dat", 128'(bus.out_dat), 128'(e_dat));
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_rel_vld",   128'(bus.out_vld), 128'd0);
        chk("hold_rel_rdy",   128'(bus.in_rdy),  128'd1);
        chk("hold_rel_msk",   128'(bus.out_msk), 128'd0);

        // Reset in the middle of a query discards everything.
        send(16'd30, 32'h3F800000, 1'b0);
        send(16'd31, 32'h40000000, 1'b0);
        send(16'd32, 32'h40400000, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_msk",    128'(bus.out_msk), 128'd0);
        chk("midrst_idx",    128'(bus.out_idx), 128'd0);
        chk("midrst_in_rdy", 128'(bus.in_rdy),  128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        e_idx = {16'd0, 16'd0, 16'd0, 16'd40};
        e_dat = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40E00000};
        e_msk = 4'b0001;
        send(16'd40, 32'h40E00000, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_topk_select.md
FP_TOPK_SELECT -- requirements
Module: fp_topk_select

Interface
REQ-001 Parameter DW, default 32: data width of one distance, IEEE-754 layout (sign MSB, magnitude below).
REQ-002 Parameter K, default 4: number of nearest candidates retained per query; legal range 1..16.
REQ-003 Parameter IW, default 16: candidate index width.
REQ-004 clk  input  1  global clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately.
REQ-006 in_vld  input  1  candidate valid.
REQ-007 in_rdy  output  1  block can accept a candidate this cycle.
REQ-008 in_idx  input  IW  candidate index.
REQ-009 in_dat  input  DW  candidate distance.
REQ-010 in_last  input  1  candidate is the final one of the current query.
REQ-011 out_vld  output  1  result set valid.
REQ-012 out_rdy  input  1  consumer accepts result set.
REQ-013 out_idx  output  K*IW  packed indices, slot 0 (smallest) in bits [IW-1:0].
REQ-014 out_dat  output  K*DW  packed distances, slot order as out_idx.
REQ-015 out_msk  output  K  bit s = 1 when slot s holds a real candidate.

Function
REQ-016 Block SHALL be the streaming sink for min-tree results: it SHALL keep, per query, the K smallest (in_dat, in_idx) pairs, sorted ascending in slots 0..K-1.
REQ-017 Ordering SHALL be sign-magnitude: negative < positive; among negatives larger magnitude is smaller; +0 and -0 SHALL compare equal.
REQ-018 Ties SHALL be stable: an incoming candidate equal to a stored one SHALL be placed after it.
REQ-019 Empty slots SHALL compare greater than every candidate; an empty slot holds idx 0, dat all-ones, msk 0.
REQ-020 FSM states: COLLECT, DONE.
REQ-021 COLLECT: in_rdy=1, out_vld=0; a transfer occurs when in_vld && in_rdy.
REQ-022 On a transfer the candidate SHALL be inserted in the same edge: slots at or after the insertion point shift up one, slot K-1 content discarded; a candidate not smaller than a full slot K-1 SHALL be dropped.
REQ-023 Insertion SHALL complete in 1 cycle; back-to-back transfers every cycle SHALL be supported with no bubbles.
REQ-024 Transfer with in_last=1 SHALL insert that candidate and move to DONE on the same edge; result includes it.
REQ-025 DONE: in_rdy=0, out_vld=1; out_idx/out_dat/out_msk SHALL stay stable until out_vld && out_rdy.
REQ-026 On out_vld && out_rdy: all slots SHALL clear to empty and FSM SHALL return to COLLECT; earliest next transfer is the following cycle.
REQ-027 Fewer than K candidates in a query: out_msk SHALL have exactly count low bits set, remaining slots empty-valued.
REQ-028 in_vld while in DONE SHALL be ignored (no transfer, no state change).
REQ-029 Result latency: out_vld SHALL assert the cycle after the in_last transfer.

Reset
REQ-030 While rst=0: FSM=COLLECT, all slots empty, out_vld=0, out_msk=0, out_idx=0, out_dat all-ones; in_rdy SHALL be 0 during reset and 1 from the first edge after release.
REQ-031 Reset asserted mid-query or in DONE SHALL discard all stored candidates and any pending result.

Verification (K=4, DW=32, IW=16)
REQ-032 Stream idx 0..5 with dat 5.0,3.0,8.0,1.0,4.0,2.0 (last on idx 5), out_rdy=1 -> one cycle later out_vld=1, out_idx={3,5,1,4} slots 0..3, out_msk=4'b1111, cleared next cycle.
REQ-033 Query of 2 candidates (idx 7 dat 2.0, idx 9 dat 1.0, last) -> out_idx slot0=9, slot1=7, out_msk=4'b0011, slots 2-3 dat=32'hFFFFFFFF.
REQ-034 Ties: idx 1 dat 2.0, idx 2 dat 2.0, idx 3 dat -0.0, idx 4 dat +0.0 last -> order {3,4,1,2}.
REQ-035 Negatives: dat -1.0, -3.0, 0.5 -> order -3.0, -1.0, 0.5.
REQ-036 Hold out_rdy=0 for 5 cycles while driving in_vld=1 -> in_rdy=0, outputs unchanged, no insertion; out_rdy=1 -> return to COLLECT next cycle.
REQ-037 Pull rst low after 3 transfers of a query -> out_msk=0 immediately; next query after release contains no stale entries.
